// File: rtl/enc8t3_seq.sv
// Sequential 8-to-3 priority encoder: loads a request vector and emits one code per Ack, lowest index first.
// Optional ENC_CNT_EN adds a registered count of the codes still pending.
module enc8t3_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       En,
  input  logic [0:7] W,
  input  logic       Ack,
  output logic       Rdy,
  output logic [2:0] Y,
  output logic       V,
`ifdef ENC_CNT_EN
  output logic [3:0] Cnt,
`endif
  output logic       Done
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t     state;
  logic [0:7] p;
  logic [0:7] p_clr;
  logic [2:0] y_w;
  logic [2:0] y_clr;

  // Index of the lowest set bit; bit 0 has the highest priority.
  function automatic logic [2:0] lowest(input logic [0:7] v);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[3'(i)]) lowest = 3'(i);
    end
  endfunction

`ifdef ENC_CNT_EN
  function automatic logic [3:0] ones(input logic [0:7] v);
    ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + 4'(v[3'(i)]);
    end
  endfunction
`endif

  // Pending vector with the code currently on Y retired, and the codes it leads to.
  always_comb begin
    p_clr    = p;
    p_clr[Y] = 1'b0;
    y_w      = lowest(W);
    y_clr    = lowest(p_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p     <= '0;
      Y     <= 3'd0;
      V     <= 1'b0;
      Done  <= 1'b0;
      Rdy   <= 1'b1;
`ifdef ENC_CNT_EN
      Cnt   <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          Done <= En && (W == 8'h00);
          if (En && (W != 8'h00)) begin
            p     <= W;
            Y     <= y_w;
            V     <= 1'b1;
            Rdy   <= 1'b0;
            state <= EMIT;
`ifdef ENC_CNT_EN
            Cnt   <= ones(W);
`endif
          end
        end
        EMIT: begin
          Done <= 1'b0;
          if (Ack) begin
            p <= p_clr;
`ifdef ENC_CNT_EN
            Cnt <= Cnt - 4'd1;
`endif
            // Last code taken: return to IDLE with a one-cycle Done.
            if (p_clr == 8'h00) begin
              state <= IDLE;
              V     <= 1'b0;
              Rdy   <= 1'b1;
              Done  <= 1'b1;
            end else begin
              Y <= y_clr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enc8t3_seq.sv
// Randomized and directed bench for enc8t3_seq against a queue-of-codes reference model.
module tb_enc8t3_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       En = 1'b0;
  logic [0:7] W = 8'h00;
  logic       Ack = 1'b0;
  logic       Rdy;
  logic [2:0] Y;
  logic       V;
  logic       Done;
`ifdef ENC_CNT_EN
  logic [3:0] Cnt;
`endif

  enc8t3_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .En   (En),
    .W    (W),
    .Ack  (Ack),
    .Rdy  (Rdy),
    .Y    (Y),
    .V    (V),
`ifdef ENC_CNT_EN
    .Cnt  (Cnt),
`endif
    .Done (Done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: the pending codes as an ordered queue; empty queue means idle.
  int   q[$];
  logic m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_done = 1'b0;
    end else if (q.size() == 0) begin
      m_done = En && (W == 8'h00);
      if (En) for (int i = 0; i < 8; i++) if (W[i]) q.push_back(i);
    end else begin
      m_done = 1'b0;
      if (Ack) begin
        void'(q.pop_front());
        m_done = (q.size() == 0);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && chk_on) begin
      chk("model_rdy", 8'(Rdy), 8'(q.size() == 0));
      chk("model_v", 8'(V), 8'(q.size() != 0));
      chk("model_done", 8'(Done), 8'(m_done));
      if (q.size() != 0) chk("model_y", 8'(Y), 8'(q[0]));
`ifdef ENC_CNT_EN
      chk("model_cnt", 8'(Cnt), 8'(q.size()));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state and a single W[0] request.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rdy", 8'(Rdy), 8'd1);
    chk("rst_v", 8'(V), 8'd0);
    chk("rst_done", 8'(Done), 8'd0);
    chk("rst_y", 8'(Y), 8'd0);
    En = 1'b1; W = 8'b1000_0000; Ack = 1'b1;
    #10 rst_n = 1'b1;
    chk_on = 1'b1;
    step();
    chk("w0_y", 8'(Y), 8'd0);
    chk("w0_v", 8'(V), 8'd1);
    chk("w0_rdy", 8'(Rdy), 8'd0);
    En = 1'b0;
    step();
    chk("w0_done", 8'(Done), 8'd1);
    chk("w0_v_low", 8'(V), 8'd0);
    chk("w0_rdy_back", 8'(Rdy), 8'd1);
    step();
    chk("w0_done_pulse", 8'(Done), 8'd0);

    // All eight codes back to back, then a new load in the Done cycle.
    En = 1'b1; W = 8'hFF; Ack = 1'b1;
    step();
    En = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("ff_y", 8'(Y), 8'(k));
`ifdef ENC_CNT_EN
      chk("ff_cnt", 8'(Cnt), 8'(8 - k));
`endif
      if (k < 7) step();
    end
    step();
    chk("ff_done", 8'(Done), 8'd1);
    chk("ff_v", 8'(V), 8'd0);
`ifdef ENC_CNT_EN
    chk("ff_cnt0", 8'(Cnt), 8'd0);
`endif
    En = 1'b1; W = 8'b0010_0100; Ack = 1'b0;
    step();
    chk("w25_y_a", 8'(Y), 8'd2);
    chk("w25_v", 8'(V), 8'd1);
    En = 1'b1; W = 8'b0000_0001;
    step();
    chk("w25_y_b", 8'(Y), 8'd2);
    En = 1'b0;
    step();
    chk("w25_y_c", 8'(Y), 8'd2);
    Ack = 1'b1;
    step();
    chk("w25_y5", 8'(Y), 8'd5);
    step();
    chk("w25_done", 8'(Done), 8'd1);

    // Zero load: Done without V.
    En = 1'b1; W = 8'h00;
    step();
    chk("zero_done", 8'(Done), 8'd1);
    chk("zero_v", 8'(V), 8'd0);
    En = 1'b0;
    step();
    chk("zero_done_off", 8'(Done), 8'd0);

    // Reset mid-emit after three Acks.
    En = 1'b1; W = 8'hFF; Ack = 1'b1;
    step();
    En = 1'b0;
    step(); step(); step();
    chk("mid_y3", 8'(Y), 8'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_v", 8'(V), 8'd0);
    chk("mid_rst_rdy", 8'(Rdy), 8'd1);
    @(negedge clk);
    rst_n = 1'b1; Ack = 1'b0;
    step();
    chk("post_rst_done", 8'(Done), 8'd0);
    En = 1'b1; W = 8'b0000_0001;
    step();
    chk("w7_y", 8'(Y), 8'd7);
    chk("w7_v", 8'(V), 8'd1);
    En = 1'b0; Ack = 1'b1;
    step();
    chk("w7_done", 8'(Done), 8'd1);

    // Random traffic, including occasional asynchronous resets.
    for (int n = 0; n < 600; n++) begin
      En  = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       W = 8'h00;
        1:       W = 8'h80 >> $urandom_range(0, 7);
        default: W = 8'($urandom);
      endcase
      Ack = ($urandom_range(0, 9) < 7);
      step();
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
